pid_heater_controller: RTL

Discrete-time PID controller that closes the temperature loop. It samples the setpoint and the plant's current_temp at a fixed sample rate and runs a multi-cycle PID computation that uses one multiplier. The result is an 8-bit heater_power command that drives the hotplate plant's heater_power input directly. The block sits directly upstream of the plant and consumes the plant's current_temp output.

---
 rtl/pid_heater_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pid_heater_controller.sv
// pid_heater_controller
// Discrete-time PID loop for the hotplate heater. Every SAMPLE_DIV enabled
// cycles the error (setpoint - current_temp) is latched. A short sequence
// then updates the integral with anti-windup, forms the derivative and
// accumulates the three gain products through one shared multiplier. The
// clamped 8-bit command goes to the plant.
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   enable       run enable; low clears all controller state on the next edge
//   setpoint     signed 16-bit target temperature
//   current_temp signed 16-bit measured plant temperature
//   heater_power registered 8-bit unsigned heater command
//   sample_valid one-cycle pulse when heater_power takes a new value
//   busy         high while a computation is in flight
module pid_heater_controller #(
  parameter int unsigned KP         = 4,
  parameter int unsigned KI         = 1,
  parameter int unsigned KD         = 2,
  parameter int unsigned FRAC_SHIFT = 2,
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned I_MAX      = 2000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] current_temp,
  output logic        [7:0]  heater_power,
  output logic               sample_valid,
  output logic               busy
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [7:0] KP8 = 8'(KP);
  localparam logic [7:0] KI8 = 8'(KI);
  localparam logic [7:0] KD8 = 8'(KD);
  localparam logic signed [24:0] IMAX_POS = 25'(I_MAX);
  localparam logic signed [24:0] IMAX_NEG = -IMAX_POS;

  typedef enum logic [2:0] {IDLE, INTEG, MUL_P, MUL_I, MUL_D, OUT} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]        cnt;
  logic signed [16:0]   error;
  logic signed [16:0]   prev_error;
  logic signed [17:0]   deriv;
  logic signed [23:0]   integral;
  logic signed [31:0]   acc;

  logic                 tick;
  logic signed [24:0]   integ_sum;
  logic signed [24:0]   integ_clamped;
  logic                 integ_hold;
  logic signed [23:0]   mul_op;
  logic        [7:0]    mul_gain;
  logic signed [31:0]   mul_a;
  logic signed [31:0]   mul_b;
  logic signed [31:0]   product;
  logic signed [31:0]   u;

  assign tick = enable && (cnt == CNT_LAST);

  // Next-state logic; a dropped enable always returns the sequence to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick) state_next = INTEG;
      INTEG:   state_next = MUL_P;
      MUL_P:   state_next = MUL_I;
      MUL_I:   state_next = MUL_D;
      MUL_D:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Anti-windup: saturation is judged on the command still held from the
  // previous sample, so pushing further into a rail freezes the integral.
  assign integ_hold = ((heater_power == 8'd255) && (error > 17'sd0)) ||
                      ((heater_power == 8'd0)   && (error < 17'sd0));
  assign integ_sum  = {integral[23], integral} + {{8{error[16]}}, error};

  always_comb begin
    integ_clamped = integ_sum;
    if (integ_sum > IMAX_POS)      integ_clamped = IMAX_POS;
    else if (integ_sum < IMAX_NEG) integ_clamped = IMAX_NEG;
  end

  // The single shared multiplier: operand and gain are steered by state.
  always_comb begin
    mul_op   = '0;
    mul_gain = '0;
    case (state_reg)
      MUL_P: begin mul_op = {{7{error[16]}}, error}; mul_gain = KP8; end
      MUL_I: begin mul_op = integral;                mul_gain = KI8; end
      MUL_D: begin mul_op = {{6{deriv[17]}}, deriv}; mul_gain = KD8; end
      default: ;
    endcase
  end

  assign mul_a   = {{8{mul_op[23]}}, mul_op};
  assign mul_b   = {24'd0, mul_gain};
  assign product = mul_a * mul_b;
  assign u       = acc >>> FRAC_SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      error        <= '0;
      prev_error   <= '0;
      deriv        <= '0;
      integral     <= '0;
      acc          <= '0;
      heater_power <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (!enable) begin
      cnt          <= '0;
      prev_error   <= '0;
      integral     <= '0;
      heater_power <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            error <= {setpoint[15], setpoint} - {current_temp[15], current_temp};
            busy  <= 1'b1;
          end
        end
        INTEG: begin
          if (!integ_hold) integral <= integ_clamped[23:0];
          deriv      <= {error[16], error} - {prev_error[16], prev_error};
          prev_error <= error;
          acc        <= '0;
        end
        MUL_P, MUL_I, MUL_D: acc <= acc + product;
        OUT: begin
          if (u < 32'sd0)        heater_power <= 8'd0;
          else if (u > 32'sd255) heater_power <= 8'd255;
          else                   heater_power <= u[7:0];
          sample_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
